// File: rtl/clarvi_arb_pkg.sv
// Shared types for the Clarvi two-master memory arbiter.
package clarvi_arb_pkg;

  typedef enum logic {
    PORT_MAIN  = 1'b0,
    PORT_INSTR = 1'b1
  } port_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD_MAIN  = 2'd1,
    HOLD_INSTR = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// Small FIFO of 1-bit owner tags for reads outstanding at the memory.
module arb_tag_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic tag_in,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] tags_q, tags_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = tags_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Full/empty come from the registered count, so a pop never frees room for a same-cycle push.
  always_comb begin
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      tags_d[wr_ptr_q] = tag_in;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Round-robin Avalon-MM arbiter: Clarvi main and instruction masters onto one memory port.
module avalon_mem_arbiter
  import clarvi_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   main_address,
  input  logic [DATA_WIDTH/8-1:0] main_byteenable,
  input  logic                    main_read,
  input  logic                    main_write,
  input  logic [DATA_WIDTH-1:0]   main_writedata,
  output logic [DATA_WIDTH-1:0]   main_readdata,
  output logic                    main_readdatavalid,
  output logic                    main_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   instr_address,
  input  logic                    instr_read,
  output logic [DATA_WIDTH-1:0]   instr_readdata,
  output logic                    instr_readdatavalid,
  output logic                    instr_waitrequest,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH/8-1:0] mem_byteenable,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH-1:0]   mem_writedata,
  input  logic [DATA_WIDTH-1:0]   mem_readdata,
  input  logic                    mem_readdatavalid,
  input  logic                    mem_waitrequest,
  output logic                    protocol_error
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  arb_state_t state_q, state_d;
  port_t      last_grant_q, last_grant_d;
  logic       perr_q, perr_d;
  port_t      sel;
  logic       sel_valid;
  logic       accept;
  logic       main_ok, instr_ok;
  logic       fifo_full, fifo_empty, fifo_head;

  // A read is only eligible while the tag FIFO has room; writes are never blocked by it.
  assign main_ok  = main_write | (main_read & ~fifo_full);
  assign instr_ok = instr_read & ~fifo_full;

  // Arbitration and next-state.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel          = PORT_MAIN;
    sel_valid    = 1'b0;
    unique case (state_q)
      HOLD_MAIN: begin
        sel       = PORT_MAIN;
        sel_valid = main_ok;
      end
      HOLD_INSTR: begin
        sel       = PORT_INSTR;
        sel_valid = instr_ok;
      end
      default: begin
        if (main_ok && instr_ok) begin
          sel       = (last_grant_q == PORT_MAIN) ? PORT_INSTR : PORT_MAIN;
          sel_valid = 1'b1;
        end else if (main_ok) begin
          sel       = PORT_MAIN;
          sel_valid = 1'b1;
        end else if (instr_ok) begin
          sel       = PORT_INSTR;
          sel_valid = 1'b1;
        end
      end
    endcase
    accept = sel_valid & ~mem_waitrequest;
    if (accept) begin
      last_grant_d = sel;
      state_d      = IDLE;
    end else if (sel_valid) begin
      state_d = (sel == PORT_MAIN) ? HOLD_MAIN : HOLD_INSTR;
    end
  end

  // Memory-side request mux and master handshakes.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    if (sel_valid) begin
      if (sel == PORT_MAIN) begin
        mem_address    = main_address;
        mem_byteenable = main_byteenable;
        mem_read       = main_read;
        mem_write      = main_write;
        mem_writedata  = main_writedata;
      end else begin
        mem_address    = instr_address;
        mem_byteenable = {BE_W{1'b1}};
        mem_read       = 1'b1;
      end
    end
  end

  assign main_waitrequest  = ~(accept && (sel == PORT_MAIN));
  assign instr_waitrequest = ~(accept && (sel == PORT_INSTR));

  arb_tag_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_tag_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (accept & mem_read),
    .tag_in (sel == PORT_INSTR),
    .pop    (mem_readdatavalid),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

  // Responses follow the oldest outstanding tag; a response with nothing outstanding is dropped.
  assign main_readdata       = mem_readdata;
  assign instr_readdata      = mem_readdata;
  assign main_readdatavalid  = mem_readdatavalid & ~fifo_empty & (fifo_head == 1'b0);
  assign instr_readdatavalid = mem_readdatavalid & ~fifo_empty & (fifo_head == 1'b1);
  assign perr_d              = perr_q | (mem_readdatavalid & fifo_empty);
  assign protocol_error      = perr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_MAIN;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      perr_q       <= perr_d;
    end
  end

endmodule
